// File: rtl/icache_pkg.sv
// Shared types and helpers for the parametrised instruction cache.
// Holds the controller state encoding, a ceil-log2 helper and address field slicers.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        INSTALL
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Address fields are returned zero-extended to 32 bits; callers size-cast to the field width.
    function automatic logic [31:0] addr_off(input logic [31:0] addr, input int off_w);
        return addr & ((32'd1 << off_w) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_idx(input logic [31:0] addr, input int off_w, input int idx_w);
        return (addr >> off_w) & ((32'd1 << idx_w) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int off_w, input int idx_w);
        return addr >> (off_w + idx_w);
    endfunction

endpackage

// File: rtl/icache_lru.sv
// True-LRU age update and victim selection for one cache set.
// Age 0 is most recently used; age WAYS-1 is the replacement candidate.
module icache_lru
    import icache_pkg::*;
#(
    parameter int WAYS  = 2,
    parameter int WAY_W = 1,
    parameter int AGE_W = 1
) (
    input  logic [WAYS*AGE_W-1:0] ages_in,
    input  logic [WAYS-1:0]       valid_in,
    input  logic [WAY_W-1:0]      access_way,
    output logic [WAYS*AGE_W-1:0] ages_out,
    output logic [WAY_W-1:0]      victim
);

    logic [AGE_W-1:0] acc_age;

    // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
    always_comb begin
        acc_age  = ages_in[access_way*AGE_W +: AGE_W];
        ages_out = ages_in;
        for (int w = 0; w < WAYS; w++) begin
            if (WAY_W'(w) == access_way)
                ages_out[w*AGE_W +: AGE_W] = '0;
            else if (ages_in[w*AGE_W +: AGE_W] < acc_age)
                ages_out[w*AGE_W +: AGE_W] = ages_in[w*AGE_W +: AGE_W] + 1'b1;
        end
    end

    // Descending scans let the lowest index win; an invalid way overrides the oldest one.
    always_comb begin
        victim = '0;
        for (int w = WAYS - 1; w >= 0; w--)
            if (ages_in[w*AGE_W +: AGE_W] == AGE_W'(WAYS - 1)) victim = WAY_W'(w);
        for (int w = WAYS - 1; w >= 0; w--)
            if (!valid_in[w]) victim = WAY_W'(w);
    end

endmodule

// File: rtl/param_icache.sv
// Parametrised set-associative read-only instruction cache with valid/ready line refill.
// Define ICACHE_STATS_EN to build the saturating hit/miss counters; otherwise they read 0.
module param_icache
    import icache_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int WORDS  = 4,
    parameter int SETS   = 2,
    parameter int WAYS   = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              flush,
    input  logic              invalidate,
    output logic              cpu_ready,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
);

    localparam int OFF_W  = clog2(WORDS);
    localparam int IDX_W  = clog2(SETS);
    localparam int IDX_WS = (IDX_W > 0) ? IDX_W : 1;
    localparam int WAY_W  = (WAYS > 1) ? clog2(WAYS) : 1;
    localparam int AGE_W  = WAY_W;
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;

    state_t state_q, state_d;

    logic [TAG_W-1:0]      tag_q    [SETS][WAYS];
    logic [DATA_W-1:0]     data_q   [SETS][WAYS][WORDS];
    logic [WAYS-1:0]       valid_q  [SETS];
    logic [WAYS*AGE_W-1:0] age_q    [SETS];
    logic [DATA_W-1:0]     line_buf [WORDS];

    logic [OFF_W-1:0]  beat_q;
    logic [ADDR_W-1:0] fill_base_q;
    logic [IDX_WS-1:0] fill_idx_q;
    logic [TAG_W-1:0]  fill_tag_q;
    logic [DATA_W-1:0] rdata_q;

    logic [OFF_W-1:0]  cpu_off;
    logic [IDX_WS-1:0] cpu_idx;
    logic [TAG_W-1:0]  cpu_tag;
    logic              hit_any, hit, miss_start, install_ok;
    logic [WAY_W-1:0]  hit_way, victim, lru_way;
    logic [IDX_WS-1:0] lru_idx;
    logic [WAYS*AGE_W-1:0] lru_ages_new;
    logic [DATA_W-1:0] hit_word;

    assign cpu_off = OFF_W'(addr_off(32'(cpu_addr), OFF_W));
    assign cpu_idx = IDX_WS'(addr_idx(32'(cpu_addr), OFF_W, IDX_W));
    assign cpu_tag = TAG_W'(addr_tag(32'(cpu_addr), OFF_W, IDX_W));

    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[cpu_idx][w] && tag_q[cpu_idx][w] == cpu_tag) begin
                hit_any = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    assign hit        = (state_q == IDLE) && cpu_req && hit_any && !invalidate;
    assign miss_start = (state_q == IDLE) && cpu_req && !hit_any && !flush && !invalidate;
    assign install_ok = (state_q == INSTALL) && !flush && !invalidate;
    assign hit_word   = data_q[cpu_idx][hit_way][cpu_off];

    assign cpu_ready = hit;
    assign cpu_rdata = hit ? hit_word : rdata_q;
    assign mem_req   = (state_q == FILL);
    assign mem_addr  = (state_q == FILL) ? (fill_base_q | ADDR_W'(beat_q)) : '0;

    // One LRU datapath serves both the hit set and the set being installed.
    assign lru_idx = (state_q == INSTALL) ? fill_idx_q : cpu_idx;
    assign lru_way = (state_q == INSTALL) ? victim : hit_way;

    icache_lru #(
        .WAYS  (WAYS),
        .WAY_W (WAY_W),
        .AGE_W (AGE_W)
    ) u_lru (
        .ages_in    (age_q[lru_idx]),
        .valid_in   (valid_q[lru_idx]),
        .access_way (lru_way),
        .ages_out   (lru_ages_new),
        .victim     (victim)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (miss_start) state_d = FILL;
            FILL:    if (mem_valid && beat_q == OFF_W'(WORDS - 1)) state_d = INSTALL;
            INSTALL: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (invalidate || flush) state_d = IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) age_q[s][w*AGE_W +: AGE_W] <= AGE_W'(w);
            end
            beat_q      <= '0;
            fill_base_q <= '0;
            fill_idx_q  <= '0;
            fill_tag_q  <= '0;
            rdata_q     <= '0;
        end else begin
            if (hit) begin
                rdata_q        <= hit_word;
                age_q[cpu_idx] <= lru_ages_new;
            end
            if (miss_start) begin
                fill_base_q <= cpu_addr & ~ADDR_W'(WORDS - 1);
                fill_idx_q  <= cpu_idx;
                fill_tag_q  <= cpu_tag;
                beat_q      <= '0;
            end
            if (state_q == FILL && mem_valid) beat_q <= beat_q + 1'b1;
            if (install_ok) begin
                valid_q[fill_idx_q][victim] <= 1'b1;
                age_q[fill_idx_q]           <= lru_ages_new;
            end
            if (invalidate)
                for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
        end
    end

    // NOTE: tag/data arrays and the line buffer are not reset; valid bits alone gate their use.
    always_ff @(posedge clk) begin
        if (state_q == FILL && mem_valid) line_buf[beat_q] <= mem_rdata;
        if (install_ok) begin
            tag_q[fill_idx_q][victim] <= fill_tag_q;
            for (int i = 0; i < WORDS; i++) data_q[fill_idx_q][victim][i] <= line_buf[i];
        end
    end

`ifdef ICACHE_STATS_EN
    logic        refill_done_q;
    logic [31:0] hit_q, miss_q;

    // The ready cycle that completes a refill belongs to the miss, not to the hit total.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            refill_done_q <= 1'b0;
            hit_q         <= '0;
            miss_q        <= '0;
        end else begin
            refill_done_q <= install_ok;
            if (hit && !refill_done_q && hit_q != '1) hit_q <= hit_q + 32'd1;
            if (miss_start && miss_q != '1) miss_q <= miss_q + 32'd1;
        end
    end

    assign hit_count  = hit_q;
    assign miss_count = miss_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule
